// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, and drives the memory handshakes and write strobes.
module core_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter logic [1:0]  RESET_PC_SEL = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  alu_op,
  input  logic [4:0]  ls_op,
  input  logic [4:0]  j_op,
  input  logic [4:0]  b_op,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_FWAIT  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_MWAIT  = 3'd5,
    ST_WB     = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      cur_st, nxt_st;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;
  logic        store_q, store_d;
  logic [31:0] instret_q;
  logic        is_jmp, is_br, is_mem, is_store, is_upper, illegal;

  assign is_jmp   = (j_op != 5'h1F);
  assign is_br    = (b_op != 5'h1F);
  assign is_store = (ls_op >= 5'd6) && (ls_op <= 5'd8);
  assign is_mem   = ((ls_op >= 5'd1) && (ls_op <= 5'd3)) || is_store;
  assign is_upper = (ls_op == 5'd4) || (ls_op == 5'd5);
  assign illegal  = (alu_op == 10'h3FF) && (ls_op == 5'h1F) && !is_jmp && !is_br;
  assign cnt_inc  = cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st    <= ST_FETCH;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
      cause_q   <= '0;
      store_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      cur_st  <= nxt_st;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      store_q <= store_d;
      if (cur_st == ST_WB) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    nxt_st   = cur_st;
    cnt_d    = cnt_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    store_d  = store_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    case (cur_st)
      ST_FETCH: begin
        imem_req = 1'b1;
        cnt_d    = '0;
        nxt_st   = ST_FWAIT;
      end
      ST_FWAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we  = 1'b1;
          nxt_st = ST_DECODE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            nxt_st  = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'd2;
          end
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          nxt_st  = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'd1;
        end else begin
          nxt_st = ST_EXEC;
        end
      end
      ST_EXEC: begin
        nxt_st = ST_WB;
        if (is_jmp) begin
          pc_we  = 1'b1;
          pc_sel = (j_op == 5'd1) ? 2'd2 : 2'd1;
          rf_we  = 1'b1;
          wb_sel = 2'd2;
        end else if (is_br) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? 2'd1 : 2'd0;
        end else if (is_mem) begin
          // Store/load kind is captured so MEM/MWAIT do not depend on the decoder later.
          store_d = is_store;
          nxt_st  = ST_MEM;
        end else begin
          pc_we  = 1'b1;
          rf_we  = 1'b1;
          wb_sel = is_upper ? 2'd3 : 2'd0;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
        cnt_d    = '0;
        nxt_st   = ST_MWAIT;
      end
      ST_MWAIT: begin
        dmem_req = 1'b1;
        dmem_we  = store_q;
        if (dmem_ack) begin
          pc_we  = 1'b1;
          rf_we  = !store_q;
          wb_sel = store_q ? 2'd0 : 2'd1;
          nxt_st = ST_WB;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            nxt_st  = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = 2'd3;
          end
        end
      end
      ST_WB:   nxt_st = ST_FETCH;
      ST_TRAP: pc_sel = RESET_PC_SEL;
      default: nxt_st = ST_FETCH;
    endcase
    // Reset parks the FSM in FETCH; the fetch request must stay low until release.
    if (!rst_n) begin
      imem_req = 1'b0;
      pc_sel   = RESET_PC_SEL;
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign state      = cur_st;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: runs single instructions through the
// sequencer with scripted ack timing and compares per-instruction traces.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  alu_op;
  logic [4:0]  ls_op, j_op, b_op;
  logic        br_taken, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;
  logic [2:0]  state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // per-instruction trace
  int unsigned cyc, rfwe_n, pcwe_n, irwe_at, dreq_n, fw, mw, imreq_n;
  logic [1:0]  wb_rf, pcs;
  logic        dwe;

  core_seq_ctrl #(.MEM_TIMEOUT(255), .RESET_PC_SEL(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .ls_op(ls_op), .j_op(j_op),
    .b_op(b_op), .br_taken(br_taken), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap),
    .trap_cause(trap_cause), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Leaves the bench 2 ns after a rising edge with the FSM in FETCH.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // iw/dw: number of wait-state cycles without ack before the ack is given.
  task automatic run_op(input logic [9:0] a, input logic [4:0] l, input logic [4:0] j,
                        input logic [4:0] b, input logic bt, input int unsigned iw,
                        input int unsigned dw);
    alu_op = a; ls_op = l; j_op = j; b_op = b; br_taken = bt;
    cyc = 0; rfwe_n = 0; pcwe_n = 0; irwe_at = 0; dreq_n = 0; fw = 0; mw = 0;
    imreq_n = 0; wb_rf = '0; pcs = '0; dwe = 1'b0;
    do begin
      cyc++;
      imem_ack = (state == 3'd1) && (fw == iw);
      dmem_ack = (state == 3'd5) && (mw == dw);
      #1;
      if (ir_we) irwe_at = cyc;
      if (imem_req) imreq_n++;
      if (rf_we) begin rfwe_n++; wb_rf = wb_sel; end
      if (pc_we) begin pcwe_n++; pcs = pc_sel; end
      if (dmem_req) begin dreq_n++; if (dmem_we) dwe = 1'b1; end
      if (state == 3'd1) fw++;
      if (state == 3'd5) mw++;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
    end while (state != 3'd0 && state != 3'd7 && cyc < 600);
    chk("bound", 32'(cyc >= 600), 32'd0);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_op = 10'h3FF; ls_op = 5'h1F; j_op = 5'h1F; b_op = 5'h1F;
    br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    do_reset();

    run_op(10'h001, 5'h1F, 5'h1F, 5'h1F, 1'b0, 0, 0);
    chk("add_cycles", cyc, 32'd5);
    chk("add_irwe_at", irwe_at, 32'd2);
    chk("add_rfwe", rfwe_n, 32'd1);
    chk("add_wbsel", 32'(wb_rf), 32'd0);
    chk("add_pcwe", pcwe_n, 32'd1);
    chk("add_pcsel", 32'(pcs), 32'd0);
    chk("add_instret", instret, 32'd1);

    run_op(10'h3FF, 5'd3, 5'h1F, 5'h1F, 1'b0, 0, 3);
    chk("lw_cycles", cyc, 32'd10);
    chk("lw_dreq", dreq_n, 32'd5);
    chk("lw_dwe", 32'(dwe), 32'd0);
    chk("lw_rfwe", rfwe_n, 32'd1);
    chk("lw_wbsel", 32'(wb_rf), 32'd1);
    chk("lw_instret", instret, 32'd2);

    run_op(10'h3FF, 5'd8, 5'h1F, 5'h1F, 1'b0, 0, 0);
    chk("sw_cycles", cyc, 32'd7);
    chk("sw_dwe", 32'(dwe), 32'd1);
    chk("sw_rfwe", rfwe_n, 32'd0);
    chk("sw_pcwe", pcwe_n, 32'd1);

    run_op(10'h3FF, 5'h1F, 5'h1F, 5'd1, 1'b0, 0, 0);
    chk("beq_nt_pcsel", 32'(pcs), 32'd0);
    chk("beq_nt_pcwe", pcwe_n, 32'd1);
    chk("beq_nt_rfwe", rfwe_n, 32'd0);
    run_op(10'h3FF, 5'h1F, 5'h1F, 5'd1, 1'b1, 0, 0);
    chk("beq_t_pcsel", 32'(pcs), 32'd1);
    chk("beq_t_rfwe", rfwe_n, 32'd0);
    chk("beq_t_cycles", cyc, 32'd5);

    run_op(10'h3FF, 5'h1F, 5'd1, 5'h1F, 1'b0, 0, 0);
    chk("jalr_pcsel", 32'(pcs), 32'd2);
    chk("jalr_rfwe", rfwe_n, 32'd1);
    chk("jalr_wbsel", 32'(wb_rf), 32'd2);
    run_op(10'h3FF, 5'h1F, 5'd2, 5'h1F, 1'b0, 0, 0);
    chk("jal_pcsel", 32'(pcs), 32'd1);
    chk("jal_wbsel", 32'(wb_rf), 32'd2);

    run_op(10'h3FF, 5'd4, 5'h1F, 5'h1F, 1'b0, 0, 0);
    chk("lui_wbsel", 32'(wb_rf), 32'd3);
    chk("lui_cycles", cyc, 32'd5);

    // jump outranks branch and load on the same instruction
    run_op(10'h3FF, 5'd3, 5'd2, 5'd1, 1'b0, 0, 0);
    chk("prio_cycles", cyc, 32'd5);
    chk("prio_pcsel", 32'(pcs), 32'd1);
    chk("prio_dreq", dreq_n, 32'd0);

    run_op(10'h001, 5'h1F, 5'h1F, 5'h1F, 1'b0, 2, 0);
    chk("iwait_cycles", cyc, 32'd7);
    chk("iwait_irwe_at", irwe_at, 32'd4);
    chk("iwait_instret", instret, 32'd10);

    dut.instret_q = 32'hFFFF_FFFF;
    run_op(10'h001, 5'h1F, 5'h1F, 5'h1F, 1'b0, 0, 0);
    chk("wrap_instret", instret, 32'd0);

    // reset while parked in MWAIT
    alu_op = 10'h3FF; ls_op = 5'd3; j_op = 5'h1F; b_op = 5'h1F;
    imem_ack = 1'b1;
    for (int i = 0; i < 20 && state != 3'd5; i++) begin
      @(posedge clk);
      #2;
    end
    imem_ack = 1'b0;
    #1;
    chk("mw_state", 32'(state), 32'd5);
    chk("mw_dreq", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mwrst_dreq", 32'(dmem_req), 32'd0);
    chk("mwrst_state", 32'(state), 32'd0);
    chk("mwrst_instret", instret, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    #1;
    chk("late_ack_rfwe", 32'(rf_we), 32'd0);
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_state", 32'(state), 32'd1);
    do_reset();

    run_op(10'h3FF, 5'h1F, 5'h1F, 5'h1F, 1'b0, 0, 0);
    chk("ill_cycles", cyc, 32'd3);
    chk("ill_state", 32'(state), 32'd7);
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_cause", 32'(trap_cause), 32'd1);
    imreq_n = 0;
    for (int i = 0; i < 6; i++) begin
      imem_ack = i[0];
      dmem_ack = i[0];
      #1;
      if (imem_req || dmem_req || pc_we || rf_we || ir_we) imreq_n++;
      @(posedge clk);
      #2;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk("ill_quiet", imreq_n, 32'd0);
    chk("ill_hold", 32'(state), 32'd7);
    chk("ill_instret", instret, 32'd0);
    do_reset();

    run_op(10'h001, 5'h1F, 5'h1F, 5'h1F, 1'b0, 1000, 0);
    chk("ito_cycles", cyc, 32'd256);
    chk("ito_state", 32'(state), 32'd7);
    chk("ito_cause", 32'(trap_cause), 32'd2);
    do_reset();

    run_op(10'h3FF, 5'd3, 5'h1F, 5'h1F, 1'b0, 0, 1000);
    chk("dto_cycles", cyc, 32'd260);
    chk("dto_cause", 32'(trap_cause), 32'd3);
    chk("dto_trap", 32'(trap), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
